// File: rtl/clk_pkg.sv
// Shared definitions for the hours/minutes/seconds clock: set-mode states and BCD field limits.
package clk_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } mode_e;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_11 = 8'h11;

endpackage

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD counter that wraps to 00 after max_bcd; carry flags the wrapping increment.
module bcd_mod_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] max_bcd,
  output logic [7:0] val,
  output logic       carry
);

  logic [7:0] val_q, val_d;

  // Wrap is decided on the full BCD value so the tens digit never runs past the field limit.
  always_comb begin
    val_d = val_q;
    if (en) begin
      if (val_q == max_bcd)       val_d = 8'h00;
      else if (val_q[3:0] == 4'd9) val_d = {val_q[7:4] + 4'd1, 4'd0};
      else                         val_d = {val_q[7:4], val_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) val_q <= 8'h00;
    else        val_q <= val_d;
  end

  assign val   = val_q;
  assign carry = en && (val_q == max_bcd);

endmodule

// File: rtl/hms_clock.sv
// Time-of-day counter driven by the NCO's 1 Hz square wave, with a button-driven time-set FSM.
module hms_clock
  import clk_pkg::*;
#(
  parameter int HOUR_MOD = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic [1:0] mode,
  output logic       day_wrap
);

  localparam logic [7:0] HOUR_MAX = (HOUR_MOD == 12) ? BCD_11 : BCD_23;

  // clk_1hz is asynchronous data: two flops to synchronise, a third for the edge.
  logic s1_q, s2_q, s3_q, tick;
  always_ff @(posedge clk) begin
    if (!rst_n) {s1_q, s2_q, s3_q} <= 3'b000;
    else        {s1_q, s2_q, s3_q} <= {clk_1hz, s1_q, s2_q};
  end
  assign tick = s2_q & ~s3_q;

  mode_e mode_q, mode_d;
  always_ff @(posedge clk) begin
    if (!rst_n) mode_q <= RUN;
    else        mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (btn_mode) begin
      case (mode_q)
        RUN:      mode_d = SET_SEC;
        SET_SEC:  mode_d = SET_MIN;
        SET_MIN:  mode_d = SET_HOUR;
        default:  mode_d = RUN;
      endcase
    end
  end

  // In set mode a mode step swallows a coincident inc, and carries are never chained.
  logic run, inc;
  logic sec_en, min_en, hour_en;
  logic sec_c, min_c, hour_c;
  assign run     = (mode_q == RUN);
  assign inc     = btn_inc & ~btn_mode;
  assign sec_en  = run ? tick  : (inc && mode_q == SET_SEC);
  assign min_en  = run ? sec_c : (inc && mode_q == SET_MIN);
  assign hour_en = run ? min_c : (inc && mode_q == SET_HOUR);

  bcd_mod_cnt u_sec (
    .clk(clk), .rst_n(rst_n), .en(sec_en), .max_bcd(BCD_59), .val(sec_bcd), .carry(sec_c)
  );
  bcd_mod_cnt u_min (
    .clk(clk), .rst_n(rst_n), .en(min_en), .max_bcd(BCD_59), .val(min_bcd), .carry(min_c)
  );
  bcd_mod_cnt u_hour (
    .clk(clk), .rst_n(rst_n), .en(hour_en), .max_bcd(HOUR_MAX), .val(hour_bcd), .carry(hour_c)
  );

  logic day_wrap_q;
  always_ff @(posedge clk) begin
    if (!rst_n) day_wrap_q <= 1'b0;
    else        day_wrap_q <= run & hour_c;
  end

  assign day_wrap = day_wrap_q;
  assign mode     = mode_q;

endmodule

// File: tb/tb_hms_clock.sv
// Directed bench for hms_clock: a 24-hour and a 12-hour instance share one stimulus stream.
module tb_hms_clock;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_1hz = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;

  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic [1:0] mode;
  logic       day_wrap;
  logic [7:0] sec12, min12, hour12;
  logic [1:0] mode12;
  logic       day_wrap12;

  int total = 0;
  int bad = 0;

  always #10 clk = ~clk;

  hms_clock #(.HOUR_MOD(24)) dut (
    .clk(clk), .rst_n(rst_n), .clk_1hz(clk_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .mode(mode), .day_wrap(day_wrap)
  );

  hms_clock #(.HOUR_MOD(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .clk_1hz(clk_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_bcd(sec12), .min_bcd(min12), .hour_bcd(hour12), .mode(mode12), .day_wrap(day_wrap12)
  );

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_mode();
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin btn_inc = 1'b1; step(); end
    btn_inc = 1'b0;
  endtask

  task automatic one_tick();
    clk_1hz = 1'b1; repeat (3) step();
    clk_1hz = 1'b0; repeat (3) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clk_1hz = 1'b1; step();
    clk_1hz = 1'b0; step();
    clk_1hz = 1'b1; step();
    clk_1hz = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_1hz = 1'b1; step();
    clk_1hz = 1'b0; step();
    clk_1hz = 1'b1; step();
    total++; if (sec_bcd !== 8'h00) begin bad++; $display("FAIL reset_sec got=%h exp=00", sec_bcd); end
    total++; if (min_bcd !== 8'h00) begin bad++; $display("FAIL reset_min got=%h exp=00", min_bcd); end
    total++; if (hour_bcd !== 8'h00) begin bad++; $display("FAIL reset_hour got=%h exp=00", hour_bcd); end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", mode); end
    total++; if (day_wrap !== 1'b0) begin bad++; $display("FAIL reset_day_wrap got=%b exp=0", day_wrap); end
    clk_1hz = 1'b0; rst_n = 1'b1;
    repeat (4) step();
    total++; if (sec_bcd !== 8'h00) begin bad++; $display("FAIL reset_no_spurious_tick got=%h exp=00", sec_bcd); end
  endtask

  task automatic test_tick_count();
    do_reset();
    clk_1hz = 1'b1;
    step();
    total++; if (sec_bcd !== 8'h00) begin bad++; $display("FAIL tick_lat_n got=%h exp=00", sec_bcd); end
    step();
    total++; if (sec_bcd !== 8'h00) begin bad++; $display("FAIL tick_lat_n1 got=%h exp=00", sec_bcd); end
    step();
    total++; if (sec_bcd !== 8'h01) begin bad++; $display("FAIL tick_lat_n2 got=%h exp=01", sec_bcd); end
    clk_1hz = 1'b0; repeat (3) step();
    total++; if (sec_bcd !== 8'h01) begin bad++; $display("FAIL tick_fall_ignored got=%h exp=01", sec_bcd); end
    for (int i = 0; i < 9; i++) one_tick();
    total++; if (sec_bcd !== 8'h10) begin bad++; $display("FAIL tick_bcd_ones_wrap got=%h exp=10", sec_bcd); end
    for (int i = 0; i < 51; i++) one_tick();
    total++; if (sec_bcd !== 8'h01) begin bad++; $display("FAIL tick61_sec got=%h exp=01", sec_bcd); end
    total++; if (min_bcd !== 8'h01) begin bad++; $display("FAIL tick61_min got=%h exp=01", min_bcd); end
    total++; if (hour_bcd !== 8'h00) begin bad++; $display("FAIL tick61_hour got=%h exp=00", hour_bcd); end
  endtask

  task automatic test_set_mode();
    do_reset();
    pulse_mode();
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL set_mode_sec got=%0d exp=1", mode); end
    pulse_inc(61);
    total++; if (sec_bcd !== 8'h01) begin bad++; $display("FAIL set_sec61 got=%h exp=01", sec_bcd); end
    total++; if (min_bcd !== 8'h00) begin bad++; $display("FAIL set_sec_no_carry got=%h exp=00", min_bcd); end
    pulse_mode(); pulse_mode();
    total++; if (mode !== 2'd3) begin bad++; $display("FAIL set_mode_hour got=%0d exp=3", mode); end
    pulse_inc(25);
    total++; if (hour_bcd !== 8'h01) begin bad++; $display("FAIL set_hour25 got=%h exp=01", hour_bcd); end
    total++; if (day_wrap !== 1'b0) begin bad++; $display("FAIL set_hour_no_wrap got=%b exp=0", day_wrap); end
    total++; if (hour12 !== 8'h01) begin bad++; $display("FAIL set_hour25_h12 got=%h exp=01", hour12); end
    one_tick(); one_tick();
    total++; if (sec_bcd !== 8'h01) begin bad++; $display("FAIL set_tick_discard_sec got=%h exp=01", sec_bcd); end
    total++; if (hour_bcd !== 8'h01) begin bad++; $display("FAIL set_tick_discard_hour got=%h exp=01", hour_bcd); end
    pulse_mode();
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL set_back_to_run got=%0d exp=0", mode); end
    one_tick();
    total++; if (sec_bcd !== 8'h02) begin bad++; $display("FAIL run_after_set got=%h exp=02", sec_bcd); end
  endtask

  task automatic test_rollover();
    do_reset();
    pulse_mode(); pulse_inc(58);
    pulse_mode(); pulse_inc(59);
    pulse_mode(); pulse_inc(23);
    pulse_mode();
    total++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h235958) begin bad++; $display("FAIL roll_preload got=%h exp=235958", {hour_bcd, min_bcd, sec_bcd}); end
    total++; if ({hour12, min12, sec12} !== 24'h115958) begin bad++; $display("FAIL roll_preload_h12 got=%h exp=115958", {hour12, min12, sec12}); end
    one_tick();
    total++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h235959) begin bad++; $display("FAIL roll_first got=%h exp=235959", {hour_bcd, min_bcd, sec_bcd}); end
    total++; if ({hour12, min12, sec12} !== 24'h115959) begin bad++; $display("FAIL roll_first_h12 got=%h exp=115959", {hour12, min12, sec12}); end
    clk_1hz = 1'b1; step(); step();
    total++; if (day_wrap !== 1'b0) begin bad++; $display("FAIL roll_wrap_early got=%b exp=0", day_wrap); end
    step();
    total++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin bad++; $display("FAIL roll_zero got=%h exp=000000", {hour_bcd, min_bcd, sec_bcd}); end
    total++; if (day_wrap !== 1'b1) begin bad++; $display("FAIL roll_wrap got=%b exp=1", day_wrap); end
    total++; if ({hour12, min12, sec12} !== 24'h000000) begin bad++; $display("FAIL roll_zero_h12 got=%h exp=000000", {hour12, min12, sec12}); end
    total++; if (day_wrap12 !== 1'b1) begin bad++; $display("FAIL roll_wrap_h12 got=%b exp=1", day_wrap12); end
    step();
    total++; if (day_wrap !== 1'b0) begin bad++; $display("FAIL roll_wrap_one_cycle got=%b exp=0", day_wrap); end
    total++; if (day_wrap12 !== 1'b0) begin bad++; $display("FAIL roll_wrap_one_cycle_h12 got=%b exp=0", day_wrap12); end
    clk_1hz = 1'b0; repeat (3) step();
  endtask

  task automatic test_collisions();
    do_reset();
    pulse_mode();
    btn_mode = 1'b1; btn_inc = 1'b1; step(); btn_mode = 1'b0; btn_inc = 1'b0;
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL coll_mode_inc_mode got=%0d exp=2", mode); end
    total++; if (sec_bcd !== 8'h00) begin bad++; $display("FAIL coll_mode_inc_sec got=%h exp=00", sec_bcd); end
    pulse_mode();
    clk_1hz = 1'b1; step(); step();
    pulse_mode();
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL coll_tick_exit_mode got=%0d exp=0", mode); end
    total++; if (sec_bcd !== 8'h00) begin bad++; $display("FAIL coll_tick_exit_sec got=%h exp=00", sec_bcd); end
    clk_1hz = 1'b0; repeat (3) step();
    total++; if (sec_bcd !== 8'h00) begin bad++; $display("FAIL coll_tick_not_queued got=%h exp=00", sec_bcd); end
    clk_1hz = 1'b1; step(); step();
    pulse_mode();
    total++; if (sec_bcd !== 8'h01) begin bad++; $display("FAIL coll_tick_enter_sec got=%h exp=01", sec_bcd); end
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL coll_tick_enter_mode got=%0d exp=1", mode); end
    clk_1hz = 1'b0; repeat (3) step();
  endtask

  task automatic test_reset_mid_set();
    do_reset();
    pulse_mode(); pulse_inc(56);
    pulse_mode(); pulse_inc(34);
    pulse_mode(); pulse_inc(12);
    pulse_mode(); pulse_mode(); pulse_mode();
    total++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h123456) begin bad++; $display("FAIL midset_preload got=%h exp=123456", {hour_bcd, min_bcd, sec_bcd}); end
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL midset_mode got=%0d exp=2", mode); end
    rst_n = 1'b0; btn_inc = 1'b1; step(); rst_n = 1'b1; btn_inc = 1'b0;
    total++; if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin bad++; $display("FAIL midset_clear got=%h exp=000000", {hour_bcd, min_bcd, sec_bcd}); end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL midset_mode_run got=%0d exp=0", mode); end
  endtask

  initial begin
    test_reset();
    test_tick_count();
    test_set_mode();
    test_rollover();
    test_collisions();
    test_reset_mid_set();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
